// File: rtl/timer_sched.sv
// Multiplexes NumReq deadline slots onto one 64-bit machine-timer compare.
// Optional late-arm counter is built only when TIMER_SCHED_MISS_CNT_EN is defined.
module timer_sched #(
  parameter int NumReq = 4,
  localparam int IdW = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [63:0]       mtime_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [IdW-1:0]    req_id_i,
  input  logic              req_cancel_i,
  input  logic [63:0]       req_deadline_i,
  output logic              cmp_valid_o,
  output logic [63:0]       cmp_value_o,
  output logic [IdW-1:0]    cmp_id_o,
  output logic [NumReq-1:0] expired_o,
  output logic              busy_o,
  output logic [15:0]       miss_cnt_o
);

  // state | meaning
  // IDLE  | accept arm/cancel requests, watch compare for expiry
  // SCAN  | walk one slot per cycle looking for the earliest armed deadline
  // FIRE  | pulse expiry for the compare slot and disarm it
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIRE = 2'd2
  } state_e;

  localparam logic [IdW-1:0] LastIdx = IdW'(NumReq - 1);

  state_e state_q, state_d;

  logic [NumReq-1:0] armed_q;
  logic [63:0]       deadline_q [NumReq];
  logic [IdW-1:0]    idx_q;
  logic              min_found_q;
  logic [63:0]       min_val_q;
  logic [IdW-1:0]    min_id_q;
  logic              cmp_valid_q;
  logic [63:0]       cmp_value_q;
  logic [IdW-1:0]    cmp_id_q;

  logic              expire_hit;
  logic              handshake;
  logic              take_slot;
  logic              sel_found;
  logic [63:0]       sel_val;
  logic [IdW-1:0]    sel_id;

  assign expire_hit = cmp_valid_q && (mtime_i >= cmp_value_q);
  assign handshake  = req_ready_o && req_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    expired_o   = '0;
    case (state_q)
      IDLE: begin
        if (expire_hit) begin
          state_d = FIRE;
        end else begin
          req_ready_o = 1'b1;
          if (req_valid_i) state_d = SCAN;
        end
      end
      SCAN: begin
        if (idx_q == LastIdx) state_d = IDLE;
      end
      FIRE: begin
        expired_o[cmp_id_q] = 1'b1;
        state_d             = SCAN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strict less-than keeps the lowest index on equal deadlines.
  always_comb begin
    take_slot = armed_q[idx_q] && (!min_found_q || (deadline_q[idx_q] < min_val_q));
    sel_found = min_found_q || armed_q[idx_q];
    sel_val   = take_slot ? deadline_q[idx_q] : min_val_q;
    sel_id    = take_slot ? idx_q : min_id_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      armed_q     <= '0;
      for (int i = 0; i < NumReq; i++) deadline_q[i] <= '0;
      idx_q       <= '0;
      min_found_q <= 1'b0;
      min_val_q   <= '0;
      min_id_q    <= '0;
      cmp_valid_q <= 1'b0;
      cmp_value_q <= '0;
      cmp_id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (handshake) begin
            armed_q[req_id_i] <= ~req_cancel_i;
            if (!req_cancel_i) deadline_q[req_id_i] <= req_deadline_i;
            idx_q       <= '0;
            min_found_q <= 1'b0;
          end
        end
        SCAN: begin
          if (idx_q == LastIdx) begin
            cmp_valid_q <= sel_found;
            cmp_value_q <= sel_found ? sel_val : '0;
            cmp_id_q    <= sel_found ? sel_id : '0;
          end else begin
            idx_q       <= idx_q + 1'b1;
            min_found_q <= sel_found;
            min_val_q   <= sel_val;
            min_id_q    <= sel_id;
          end
        end
        FIRE: begin
          armed_q[cmp_id_q] <= 1'b0;
          cmp_valid_q       <= 1'b0;
          idx_q             <= '0;
          min_found_q       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cmp_valid_o = cmp_valid_q;
  assign cmp_value_o = cmp_value_q;
  assign cmp_id_o    = cmp_id_q;
  assign busy_o      = (state_q != IDLE);

`ifdef TIMER_SCHED_MISS_CNT_EN
  logic [15:0] miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miss_cnt_q <= '0;
    end else if (handshake && !req_cancel_i && (req_deadline_i <= mtime_i)
                 && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign miss_cnt_o = miss_cnt_q;
`else
  assign miss_cnt_o = '0;
`endif

endmodule

// File: doc/timer_sched.md
# timer_sched

Deadline scheduler that multiplexes up to `NumReq` software timer slots onto the single 64-bit compare of the RISC-V machine timer. Requesters arm or cancel a slot through a shared valid/ready port. A sequential scan FSM selects the earliest armed deadline and presents it as the compare value/id for the timer datapath. When `mtime_i` reaches that deadline, the scheduler emits a one-cycle per-slot expiry pulse, disarms the slot and rescans.

## Interface
- `NumReq`, 4, number of timer slots (2..16)
- `IdW`, `$clog2(NumReq)`, slot id width (derived; not overridden)
- `clk_i` in 1: clock
- `rst_ni` in 1: asynchronous active-low reset
- `mtime_i` in 64: current timer value, free-running
- `req_valid_i` in 1: request valid
- `req_ready_o` out 1: request accepted when valid && ready
- `req_id_i` in IdW: target slot
- `req_cancel_i` in 1: 1 = disarm slot, 0 = arm slot with deadline
- `req_deadline_i` in 64: absolute deadline (ignored on cancel)
- `cmp_valid_o` out 1: an armed slot exists; compare fields meaningful
- `cmp_value_o` out 64: earliest armed deadline
- `cmp_id_o` out IdW: slot holding `cmp_value_o`
- `expired_o` out NumReq: one-hot, one-cycle expiry pulse
- `busy_o` out 1: FSM not in IDLE
- `miss_cnt_o` out 16: late-arm counter (see Configuration)

## Operation
- State per slot: `armed` bit and 64-bit `deadline`. Reset clears all `armed`; deadlines reset to 0.
- FSM states:
  - IDLE
  - SCAN (index counter 0..NumReq-1)
  - FIRE
- IDLE:
  - If `cmp_valid_o && mtime_i >= cmp_value_o`, go to FIRE. Expiry has priority: `req_ready_o`=0 in that cycle.
  - Otherwise `req_ready_o`=1.
  - On handshake: arm writes `armed`=1 and the deadline, overwriting any prior arm. Cancel writes `armed`=0.
  - After a handshake, go to SCAN with index 0. Cancelling an unarmed slot is legal and still triggers a scan.
- SCAN:
  - One slot examined per cycle.
  - The running minimum is updated only on strict `<`, so ties resolve to the lowest index.
  - After index NumReq-1, `cmp_valid_o`/`cmp_value_o`/`cmp_id_o` load the result (`cmp_valid_o`=0 if no slot is armed). Then go to IDLE.
- FIRE:
  - `expired_o[cmp_id_o]`=1 for exactly this cycle.
  - The slot is disarmed and `cmp_valid_o` is cleared.
  - Then go to SCAN.
- Comparison is unsigned 64-bit; no wrap handling (wrap at 2^64 is out of scope).
- A deadline already ≤ `mtime_i` when armed is accepted and fires immediately after its scan.
- During SCAN/FIRE the compare outputs hold stale values. The expiry check runs only in IDLE, so stale compares never fire.

## Timing
- Reset values:
  - `req_ready_o`=1 (IDLE), all other outputs 0.
  - `busy_o`=0, `expired_o`=0, `cmp_*`=0, `miss_cnt_o`=0.
- Arm/cancel accepted at cycle T:
  - SCAN occupies T+1..T+NumReq.
  - New `cmp_*` is visible from T+NumReq+1, when IDLE resumes and `req_ready_o`=1.
- Expiry:
  - Condition true in IDLE at cycle E.
  - `expired_o` pulses in E+1 (FIRE).
  - Rescan runs E+2..E+1+NumReq.
  - Next expiry pulse is no earlier than E+3+NumReq.
- `busy_o` = (state != IDLE), registered state decode.
- Requests presented while `req_ready_o`=0 are held by the requester: valid must stay high and the fields stable until the handshake.
- Asynchronous reset mid-SCAN or mid-FIRE returns to IDLE, disarms every slot and suppresses any pending pulse.

## Configuration
- `TIMER_SCHED_MISS_CNT_EN` defined:
  - `miss_cnt_o` is a 16-bit saturating counter.
  - It increments on every accepted arm with `req_deadline_i <= mtime_i`.
  - It saturates at 0xFFFF and clears only on reset.
- Undefined: `miss_cnt_o` is tied to 0 and no counter logic is built.

## Test plan
- **Single arm:** reset, `mtime_i`=100, arm id 2 deadline 150 at T → `cmp_valid_o`=1, `cmp_value_o`=150, `cmp_id_o`=2 at T+5. Ramp `mtime_i` to 150 → `expired_o`=4'b0100 for one cycle, then `cmp_valid_o`=0.
- **Earliest selection and tie:** arm id0=500, id3=300, id1=300 → `cmp_id_o`=1, value 300. At mtime 300, id1 fires, then id3 fires ≥NumReq+2 cycles later, then id0 at 500.
- **Cancel and overwrite:**
  - Arm id0=200, cancel id0 → `cmp_valid_o`=0 and no pulse at mtime 200.
  - Re-arm id0=200 then id0=400 → single pulse at mtime 400.
- **Late arm and priority:**
  - With `mtime_i`=1000, arm id1=10 → pulse on id1 within NumReq+2 cycles of acceptance.
  - `miss_cnt_o`=1 with `TIMER_SCHED_MISS_CNT_EN` defined, 0 without.
  - A request held during an expiry-eligible IDLE cycle sees `req_ready_o`=0.
- **Reset mid-operation:** assert `rst_ni`=0 during SCAN after arming id2 → all outputs 0, `req_ready_o`=1 after release, no `expired_o` pulse even when `mtime_i` passes the old deadline.
